// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit running beside the single-cycle EX stage.
// Stalls the pipeline through hold_flag_o and writes the result back as a one-cycle strobe.
//
// state | meaning
// IDLE  | waiting for start_i from EX decode
// MUL   | product travelling through the multiplier pipeline
// DIV   | restoring divide iterations, then the sign-fixup cycle
// DONE  | result valid, rd_wen_o strobes unless flushed or rd = x0
module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int CNT_W     = $clog2(DIV_ITERS + 1);
    localparam int MUL_LOAD  = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam int PIPE_D    = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]                   f3_q;
    logic [4:0]                   rd_addr_q;
    logic [XLEN-1:0]              quo_q, rem_q, dvs_q, result_q;
    logic                         neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [PIPE_D-1:0][2*XLEN-1:0] prod_q;

    logic            accept, is_div, div_signed, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res, op1_abs, op2_abs;
    logic [XLEN-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix, div_result;
    logic [2*XLEN-1:0] mul_a, mul_b, prod_comb, prod_final;
    logic [1:0]      mul_f3;
    logic [XLEN-1:0] mul_result;

    assign accept     = start_i & (state_q == S_IDLE) & ~flush_i;
    assign is_div     = funct3_i[2];
    assign div_signed = ~funct3_i[0];
    assign div_zero   = (op2_i == '0);
    assign div_ovf    = div_signed & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
    assign special    = is_div & (div_zero | div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3_i[1] ? op1_i : '1;
        else
            special_res = funct3_i[1] ? '0 : op1_i;
    end

    assign op1_abs = (div_signed & op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign op2_abs = (div_signed & op2_i[XLEN-1]) ? -op2_i : op2_i;

    // Operands sign- or zero-extended to 2*XLEN so one unsigned multiply covers all four ops.
    assign mul_a = {{XLEN{op1_i[XLEN-1] & (funct3_i[1:0] != 2'b11)}}, op1_i};
    assign mul_b = {{XLEN{op2_i[XLEN-1] & (funct3_i[1:0] == 2'b01)}}, op2_i};
    assign prod_comb = mul_a * mul_b;

    // A single-cycle multiply captures straight from the inputs at the start edge.
    assign prod_final = (MUL_CYCLES == 1) ? prod_comb : prod_q[PIPE_D-1];
    assign mul_f3     = (MUL_CYCLES == 1) ? funct3_i[1:0] : f3_q;
    assign mul_result = (mul_f3 == 2'b00) ? prod_final[XLEN-1:0] : prod_final[2*XLEN-1:XLEN];

    always_comb begin
        logic [XLEN:0]   t;
        logic [XLEN-1:0] r, q;
        r = rem_q;
        q = quo_q;
        t = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            t = {r, q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (t >= {1'b0, dvs_q}) begin
                t    = t - {1'b0, dvs_q};
                q[0] = 1'b1;
            end
            r = t[XLEN-1:0];
        end
        quo_nxt = q;
        rem_nxt = r;
    end

    assign quo_fix    = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix    = neg_rem_q ? -rem_q : rem_q;
    assign div_result = f3_q[1] ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        rd_wen_o    = 1'b0;
        hold_flag_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (special)
                        state_d = S_DONE;
                    else if (is_div)
                        state_d = S_DIV;
                    else if (MUL_CYCLES == 1)
                        state_d = S_DONE;
                    else
                        state_d = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                busy_o = 1'b1;
                if (cnt_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rd_wen_o = ~flush_i & (rd_addr_q != 5'd0);
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i)
            state_d = S_IDLE;
        hold_flag_o = accept | busy_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q      <= '0;
            rd_addr_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
        end else begin
            prod_q[0] <= prod_comb;
            for (int i = 1; i < PIPE_D; i++)
                prod_q[i] <= prod_q[i-1];

            if (accept) begin
                f3_q      <= funct3_i[1:0];
                rd_addr_q <= rd_addr_i;
                quo_q     <= op1_abs;
                dvs_q     <= op2_abs;
                rem_q     <= '0;
                neg_quo_q <= div_signed & (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
                neg_rem_q <= div_signed & op1_i[XLEN-1];
                cnt_q     <= is_div ? CNT_W'(DIV_ITERS) : CNT_W'(MUL_LOAD);
                if (special)
                    result_q <= special_res;
                else if (!is_div && MUL_CYCLES == 1)
                    result_q <= mul_result;
            end else if (state_q == S_MUL) begin
                if (cnt_q == '0)
                    result_q <= mul_result;
                else
                    cnt_q <= cnt_q - CNT_W'(1);
            end else if (state_q == S_DIV) begin
                // Counter at zero marks the sign-fixup cycle after the last iteration.
                if (cnt_q == '0) begin
                    result_q <= div_result;
                end else begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign rd_data_o = result_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected writes are queued at issue time
// from an arithmetic reference model and matched by an independent write monitor.
module tb_ex_muldiv_unit;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_BITS   = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i, op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o, hold_flag_o, rd_wen_o;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr_o;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .hold_flag_o(hold_flag_o), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [4:0]      addr;
        int              at;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < 3'd4) return MUL_CYCLES;
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN / DIV_BITS + 2;
    endfunction

    // Called at a negedge; returns at the negedge after the op has fully retired.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int poke_at, input int flush_at);
        int   lat;
        exp_t e;
        lat = ref_lat(f3, a, b);
        start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd;
        if (flush_at == 0 && rd != 0) begin
            e.data = ref_model(f3, a, b);
            e.addr = rd;
            e.at   = cyc + lat;
            sb.push_back(e);
        end
        #1 check("hold_on_start", {31'b0, hold_flag_o}, 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        op1_i = $urandom; op2_i = $urandom; funct3_i = 3'($urandom); rd_addr_i = 5'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k == flush_at) flush_i = 1'b1;
            if (k == poke_at) start_i = 1'b1;
            #1;
            if (k < lat) begin
                check("busy_mid", {31'b0, busy_o}, 32'd1);
                check("hold_mid", {31'b0, hold_flag_o}, 32'd1);
            end else begin
                check("hold_done", {31'b0, hold_flag_o}, 32'd0);
            end
            if (k == flush_at && k == lat)
                check("flush_done_wen", {31'b0, rd_wen_o}, 32'd0);
            @(negedge clk);
            flush_i = 1'b0;
            start_i = 1'b0;
            if (k == flush_at) begin
                #1 check("flush_to_idle", {31'b0, busy_o}, 32'd0);
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Write monitor, sampled mid-cycle well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rd_wen_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {27'b0, rd_addr_o}, 32'd0);
                    check("unexpected_write_flag", 32'd1, 32'd0 + {31'b0, sb.size() != 0});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_data", rd_data_o, e.data);
                    check("wr_addr", {27'b0, rd_addr_o}, {27'b0, e.addr});
                    check("wr_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_hold", {31'b0, hold_flag_o}, 32'd0);
        check("rst_wen", {31'b0, rd_wen_o}, 32'd0);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_addr", {27'b0, rd_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0);
        issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, 0);
        issue(3'd5, 32'd100, 32'd0, 5'd11, 0, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 0);
        issue(3'd7, 32'd5, 32'd0, 5'd14, 0, 0);
        issue(3'd7, 32'd1000, 32'd7, 5'd15, 0, 0);

        // Flush mid-divide, then a multiply straight after.
        issue(3'd4, 32'd12345, 32'd3, 5'd16, 0, 10);
        issue(3'd0, 32'd3, 32'd4, 5'd17, 0, 0);
        // Flush landing in the DONE cycle of a special case.
        issue(3'd5, 32'd1, 32'd0, 5'd18, 0, 1);
        // Start pulses while busy / in DONE must be ignored.
        issue(3'd4, 32'd1000, 32'd7, 5'd19, 3, 0);
        issue(3'd5, 32'd9, 32'd0, 5'd20, 1, 0);
        // x0 destination never writes.
        issue(3'd0, 32'd5, 32'd6, 5'd0, 0, 0);

        // Reset in the middle of a divide.
        start_i = 1'b1; funct3_i = 3'd4; op1_i = 32'd777; op2_i = 32'd5; rd_addr_i = 5'd21;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_hold", {31'b0, hold_flag_o}, 32'd0);
        check("midrst_wen", {31'b0, rd_wen_o}, 32'd0);
        check("midrst_data", rd_data_o, 32'd0);
        check("midrst_addr", {27'b0, rd_addr_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_op();
            b  = pick_op();
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(f3, a, b, rd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle RV32M execute unit that runs beside the single-cycle EX stage.
- Takes already-forwarded operands from EX when an OP-type instruction has funct7 = 0000001.
- Runs MUL/MULH/MULHSU/MULHU through a latency-configurable multiplier, and DIV/DIVU/REM/REMU through an iterative radix-2^DIV_BITS divider.
- Stalls the pipeline via hold_flag_o until the result is ready, then emits a one-cycle register write.

Parameters:
- XLEN, 32: operand/result width; must be even and ≥ 8.
- MUL_CYCLES, 2: start-to-result latency for multiplies; legal range 1..4.
- DIV_BITS, 1: quotient bits produced per divider iteration; 1 or 2; XLEN must be divisible by DIV_BITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  launch request; single cycle, qualified by EX decode
- funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op1_i  in  XLEN  rs1 value, already forwarded
- op2_i  in  XLEN  rs2 value, already forwarded
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill in-flight operation (jump/branch taken)
- busy_o  out  1  state is MUL or DIV
- hold_flag_o  out  1  stall request to control
- rd_data_o  out  XLEN  result
- rd_addr_o  out  5  destination register
- rd_wen_o  out  1  one-cycle write strobe

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0; state IDLE.
  - Internal operand, counter and quotient/remainder registers cleared.
- States and transitions:
  - IDLE -> MUL when start_i and funct3_i[2]=0.
  - IDLE -> DIV when start_i, funct3_i[2]=1 and the operation is not a special case.
  - IDLE -> DONE when start_i and the operation is a special case.
  - MUL/DIV -> DONE when the iteration counter reaches its terminal count.
  - DONE -> IDLE unconditionally.
- Acceptance:
  - start_i is accepted only in IDLE; it is ignored in any other state.
  - On acceptance, latch funct3_i, op1_i, op2_i and rd_addr_i.
  - Operands may change after the start cycle without affecting the result.
- Latency: with the start edge as cycle 0, rd_wen_o is high for exactly one cycle at cycle L.
  - Multiply: L = MUL_CYCLES.
  - Divide/remainder: L = XLEN/DIV_BITS + 2 (one setup cycle, iterations, one sign-fixup cycle).
  - Special cases: L = 1.
- rd_data_o and rd_addr_o are valid only while rd_wen_o = 1.
  - They hold their last value otherwise; the bench checks them only while rd_wen_o = 1.
- hold_flag_o:
  - Combinational: (start_i & state==IDLE & ~flush_i) | busy_o.
  - Low in DONE, so the stalled instruction advances together with the write.
  - rd_wen_o is forced low when rd_addr_o = 0.
- Multiply:
  - Full 2*XLEN product.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
  - Intermediate product is pipelined across MUL_CYCLES registers.
- Divide:
  - Signed ops operate on absolute values.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1); both applied in the fixup cycle.
  - Unsigned ops skip negation.
- Special cases (RISC-V defined results, no trap):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op1.
  - Signed overflow (op1 = 1 followed by XLEN-1 zeros, op2 = all ones): DIV -> op1; REM -> 0.
- Flush:
  - flush_i in any state returns the unit to IDLE on the next edge.
  - No rd_wen_o is produced for the killed operation.
  - flush_i together with start_i: the start is ignored.
  - flush_i in DONE: rd_wen_o is suppressed in that cycle.
- Back-to-back operations: a new start_i is accepted in the IDLE cycle that follows DONE; there is no dead cycle beyond that.
- Reset mid-operation: rst_n low aborts immediately; no write issues after reset is released.

Test Plan:
- MUL 7 × -3 (op2 = 0xFFFFFFFD), rd = 5 -> rd_wen_o at cycle 2 with rd_data_o = 0xFFFFFFEB, rd_addr_o = 5; hold_flag_o high in cycles 0-1.
- MULH / MULHSU / MULHU with op1 = 0x80000000, op2 = 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -7 / 2 and REM -7 / 2 (op1 = 0xFFFFFFF9) -> 0xFFFFFFFD and 0xFFFFFFFF, written at cycle 34 (DIV_BITS = 1) and at cycle 18 (DIV_BITS = 2).
- DIVU 100 / 0 -> 0xFFFFFFFF at cycle 1; REM with op1 = 0x80000000, op2 = 0xFFFFFFFF -> 0 at cycle 1; DIV with the same operands -> 0x80000000.
- Start a DIV, assert flush_i at cycle 10 -> IDLE at cycle 11, no rd_wen_o pulse; an immediate new MUL 3 × 4 then writes 12 at its normal latency.
- Start a DIV, drop rst_n at cycle 5 -> all outputs 0 asynchronously; a start_i asserted while busy is ignored; rd_addr = 0 produces no write.
